// File: rtl/sipo_pkg.sv
// Shared definitions for the serial/parallel converter family: bit-order encodings and counter sizing.
package sipo_pkg;

  localparam bit ORDER_MSB = 1'b1;
  localparam bit ORDER_LSB = 1'b0;

  // The counter must reach WIDTH itself (the FULL state), hence WIDTH+1 codes.
  function automatic int cnt_w_f(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register: loads a finished word, holds it until the consumer takes it.
// Latency 0 (word visible after the load edge); slot_free reports whether a load can land this cycle.
module sipo_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_word_i,
  input  logic             p_ready_i,
  output logic [WIDTH-1:0] p_out_o,
  output logic             p_valid_o,
  output logic             slot_free_o
);

  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;

  assign slot_free_o = !p_valid_q | p_ready_i;

  // clear drops the valid flag but deliberately leaves the last word on p_out.
  always_comb begin
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    if (clear_i) begin
      p_valid_d = 1'b0;
    end else if (load_i) begin
      p_out_d   = load_word_i;
      p_valid_d = 1'b1;
    end else if (p_ready_i) begin
      p_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
    end else begin
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign p_out_o   = p_out_q;
  assign p_valid_o = p_valid_q;

endmodule

// File: rtl/sipo_stream.sv
// Serial-in/parallel-out deserialiser with valid/ready on both sides and a one-word holding register.
// 1 bit/clk sustained; when the holder is occupied the shifter parks its completed word and drops s_ready.
module sipo_stream
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = ORDER_MSB,
  parameter int CNT_W     = cnt_w_f(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             s_in,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift, load_word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, slot_free, load;

  generate
    if (MSB_FIRST == ORDER_MSB) begin : g_msb
      assign sr_shift = {sr_q[WIDTH-2:0], s_in};
    end else begin : g_lsb
      assign sr_shift = {s_in, sr_q[WIDTH-1:1]};
    end
  endgenerate

  assign s_ready = (cnt_q != CNT_FULL);
  assign accept  = s_valid & s_ready;
  assign bit_cnt = cnt_q;

  // The word completing on this edge bypasses sr and goes straight to the holder.
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_word = sr_shift;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (cnt_q == CNT_FULL) begin
      if (slot_free) begin
        load      = 1'b1;
        load_word = sr_q;
        cnt_d     = '0;
      end
    end else if (accept) begin
      sr_d = sr_shift;
      if (cnt_q == CNT_LAST) begin
        if (slot_free) begin
          load  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = CNT_FULL;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .load_i     (load),
    .load_word_i(load_word),
    .p_ready_i  (p_ready),
    .p_out_o    (p_out),
    .p_valid_o  (p_valid),
    .slot_free_o(slot_free)
  );

endmodule
